// File: rtl/binary_decoder_138.sv
// rtl/binary_decoder_138.sv - registered 3-to-8 decoder with 74x138-style enables, active-low outputs
module binary_decoder_138 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       G1,
  input  logic       G2A,
  input  logic       G2B,
  output logic [7:0] Y_
);

  logic       en;
  logic [2:0] sel;
  logic [7:0] next_y;

  assign en  = G1 & ~G2A & ~G2B;
  assign sel = {C, B, A};

  // Only all-ones or a single cleared bit can ever reach the register.
  always_comb begin
    next_y = 8'hFF;
    if (en) begin
      next_y[sel] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y_ <= 8'hFF;
    end else begin
      Y_ <= next_y;
    end
  end

endmodule

// File: tb/tb_binary_decoder_138.sv
// tb/tb_binary_decoder_138.sv - self-checking bench for binary_decoder_138
module tb_binary_decoder_138;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       A = 1'b0, B = 1'b0, C = 1'b0;
  logic       G1 = 1'b0, G2A = 1'b0, G2B = 1'b0;
  logic [7:0] Y_;

  int checks = 0;
  int errors = 0;

  binary_decoder_138 dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C),
    .G1(G1), .G2A(G2A), .G2B(G2B), .Y_(Y_)
  );

  always #5 clk = ~clk;

  // Reference: all lines high, minus the weight of the selected line when enabled.
  function automatic logic [7:0] ref_decode(input int s, input bit g1, input bit g2a, input bit g2b);
    int v;
    v = 255;
    if (g1 && !g2a && !g2b) v = 255 - (2 ** s);
    return v[7:0];
  endfunction

  // Drive a full input vector, then sample 1 time unit after the capturing edge.
  task automatic apply(input bit rst, input int s, input bit g1, input bit g2a, input bit g2b);
    rst_n = rst;
    A = s[0]; B = s[1]; C = s[2];
    G1 = g1; G2A = g2a; G2B = g2b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (Y_ === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, Y_, exp);
    end
  endtask

  initial begin
    int s;
    bit g1, g2a, g2b;
    logic [7:0] exp;

    apply(1'b0, 0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("reset", 8'hFF);

    apply(1'b1, 0, 1'b0, 1'b0, 1'b0);
    check("g1_low", 8'hFF);

    for (int i = 0; i < 4; i++) begin
      s = (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 3 : 7;
      apply(1'b1, s, 1'b1, 1'b1, 1'b1);
      check("g2_both_high", 8'hFF);
    end
    apply(1'b1, 1, 1'b1, 1'b0, 1'b1);
    check("g2b_high", 8'hFF);
    apply(1'b1, 3, 1'b1, 1'b1, 1'b0);
    check("g2a_high", 8'hFF);

    for (int i = 0; i < 8; i++) begin
      apply(1'b1, i, 1'b1, 1'b0, 1'b0);
      check($sformatf("sweep_%0d", i), ref_decode(i, 1'b1, 1'b0, 1'b0));
    end

    apply(1'b1, 3, 1'b1, 1'b0, 1'b0);
    check("bitorder_ab", 8'hF7);
    apply(1'b1, 1, 1'b1, 1'b0, 1'b0);
    check("bitorder_a", 8'hFD);

    apply(1'b1, 5, 1'b1, 1'b0, 1'b0);
    check("pre_reset", 8'hDF);
    apply(1'b0, 5, 1'b1, 1'b0, 1'b0);
    check("mid_reset", 8'hFF);
    apply(1'b1, 5, 1'b1, 1'b0, 1'b0);
    check("post_reset", 8'hDF);

    for (int i = 0; i < 1000; i++) begin
      s   = int'($urandom_range(0, 7));
      g1  = ($urandom_range(0, 3) != 0);
      g2a = ($urandom_range(0, 3) == 0);
      g2b = ($urandom_range(0, 3) == 0);
      apply(1'b1, s, g1, g2a, g2b);
      exp = ref_decode(s, g1, g2a, g2b);
      check("random", exp);
      checks++;
      assert ($countones(~Y_) <= 1) else begin
        errors++;
        $error("FAIL onecold observed=%h expected=at_most_one_zero", Y_);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
